// File: rtl/reaction_display_pkg.sv
// Shared types and constants for the reaction-time display.
// FSM encodings, segment codes and small helper functions.
`timescale 1ns/1ps
package reaction_display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int BIN_W = 13;
   localparam int BCD_W = 16;
   localparam int CNT_W = 20;

   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_DASH  = 8'hBF;

   function automatic logic [7:0] seg_code(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Double-dabble correction: add 3 to each nibble that is 5 or more
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < 4; i++) begin
         if (b[i*4 +: 4] >= 4'd5)
            r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
      return r;
   endfunction

endpackage

// File: rtl/reaction_display_bin2bcd_seq.sv
// Sequential 13-bit binary to 4-digit BCD converter.
// One double-dabble step per cycle, then one DONE cycle.
`timescale 1ns/1ps
module bin2bcd_seq
   import reaction_display_pkg::*;
(
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);

   state_t                   st;
   logic [3:0]               cnt;
   logic [BCD_W+BIN_W-1:0]   sr;
   logic [BCD_W+BIN_W-1:0]   adj;

   assign adj  = {add3(sr[BCD_W+BIN_W-1:BIN_W]), sr[BIN_W-1:0]};
   assign bcd  = sr[BCD_W+BIN_W-1:BIN_W];
   assign done = (st == DONE);

   // Conversion FSM: capture, 13 shift steps, one result cycle
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         st   <= IDLE;
         cnt  <= '0;
         sr   <= '0;
         busy <= 1'b0;
      end else begin
         unique case (st)
            IDLE: begin
               if (start && !busy) begin
                  sr   <= {{BCD_W{1'b0}}, bin};
                  cnt  <= '0;
                  busy <= 1'b1;
                  st   <= SHIFT;
               end
            end
            SHIFT: begin
               sr  <= {adj[BCD_W+BIN_W-2:0], 1'b0};
               cnt <= cnt + 4'd1;
               if (cnt == 4'(BIN_W-1))
                  st <= DONE;
            end
            DONE: begin
               busy <= 1'b0;
               st   <= IDLE;
            end
            default: begin
               busy <= 1'b0;
               st   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/reaction_display.sv
// Reaction-time display: converts a ms value to BCD and
// multiplexes it onto four active-low seven-segment digits.
`timescale 1ns/1ps
module reaction_display
   import reaction_display_pkg::*;
#(
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_LEAD = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [BIN_W-1:0] number,
   input  logic             load,
   input  logic             foul,
   output logic             busy,
   output logic [3:0]       an,
   output logic [7:0]       seg
);

   logic             done;
   logic [BCD_W-1:0] bcd;
   logic [BCD_W-1:0] disp;
   logic [BCD_W-1:0] disp_nx;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       idx;
   logic [1:0]       idx_nx;
   logic             wrap;
   logic [3:0]       an_r;
   logic [3:0]       an_nx;
   logic [7:0]       seg_r;
   logic [7:0]       seg_nx;
   logic [3:0]       digit;
   logic [BCD_W-1:0] upper;
   logic             blank;

   bin2bcd_seq u_conv (
      .clk   (clk),
      .clr   (clr),
      .start (load),
      .bin   (number),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   assign wrap    = (cnt == CNT_W'(SCAN_DIV - 1));
   assign idx_nx  = wrap ? idx + 2'd1 : idx;
   assign disp_nx = done ? bcd : disp;

   // Next digit enable and segment pattern, with leading-zero blanking
   always_comb begin
      an_nx  = ~(4'b0001 << idx_nx);
      digit  = disp_nx[{idx_nx, 2'b00} +: 4];
      upper  = disp_nx >> {idx_nx, 2'b00};
      blank  = (BLANK_LEAD != 0) && (idx_nx != 2'd0)
               && (upper == '0);
      seg_nx = blank ? SEG_BLANK : seg_code(digit);
   end

   // Scan counter, digit index, display register and output registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt   <= '0;
         idx   <= '0;
         disp  <= '0;
         an_r  <= 4'b1110;
         seg_r <= SEG_0;
      end else begin
         cnt   <= wrap ? '0 : cnt + 1'b1;
         idx   <= idx_nx;
         disp  <= disp_nx;
         an_r  <= an_nx;
         seg_r <= seg_nx;
      end
   end

   assign an  = an_r;
   assign seg = foul ? SEG_DASH : seg_r;

endmodule

// File: tb/tb_reaction_display.sv
// Self-checking bench for reaction_display with a fast scan rate.
// Expected digits come from decimal arithmetic on the loaded value.
`timescale 1ns/1ps
module tb_reaction_display;

   logic        clk = 1'b0;
   logic        clr = 1'b0;
   logic [12:0] number = '0;
   logic        load = 1'b0;
   logic        foul = 1'b0;
   logic        busy;
   logic [3:0]  an;
   logic [7:0]  seg;

   int checks = 0;
   int errors = 0;
   int shown  = 0;

   localparam logic [7:0] TBL [10] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
   };

   reaction_display #(
      .SCAN_DIV   (4),
      .BLANK_LEAD (1)
   ) dut (
      .clk    (clk),
      .clr    (clr),
      .number (number),
      .load   (load),
      .foul   (foul),
      .busy   (busy),
      .an     (an),
      .seg    (seg)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_seg(input int v, input int pos);
      int p;
      p = 1;
      for (int i = 0; i < pos; i++) p = p * 10;
      if (pos > 0 && v < p) return 8'hFF;
      return TBL[(v / p) % 10];
   endfunction

   function automatic int pos_of(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic check_display(input string name, input int v);
      int p;
      for (int k = 0; k < 16; k++) begin
         p = pos_of(an);
         checks++;
         if (p < 0 || seg !== exp_seg(v, p)) begin
            errors++;
            $display("FAIL %s: an=%b seg=%h expected digit of %0d seg=%h",
                     name, an, seg, v, exp_seg(v, (p < 0) ? 0 : p));
         end
         tick();
      end
   endtask

   // Pulse load, optionally re-pulse during busy, check hold and busy length
   task automatic do_load(input string name, input int v,
                          input int extra_at, input int extra);
      int n;
      int p;
      number = 13'(v);
      load   = 1'b1;
      tick();
      load   = 1'b0;
      n      = 0;
      while (busy === 1'b1 && n < 40) begin
         p = pos_of(an);
         checks++;
         if (p < 0 || seg !== exp_seg(shown, p)) begin
            errors++;
            $display("FAIL %s_hold: an=%b seg=%h expected old %0d",
                     name, an, seg, shown);
         end
         if (n == extra_at) begin
            number = 13'(extra);
            load   = 1'b1;
         end else begin
            load   = 1'b0;
         end
         n++;
         tick();
      end
      load = 1'b0;
      checks++;
      if (n != 14) begin
         errors++;
         $display("FAIL %s_busy: busy cycles %0d expected 14", name, n);
      end
      shown = v;
      check_display(name, v);
   endtask

   task automatic test_reset;
      load = 1'b1;
      #12;
      checks++;
      if (busy !== 1'b0 || an !== 4'b1110 || seg !== 8'hC0) begin
         errors++;
         $display("FAIL reset: busy=%b an=%b seg=%h expected 0 1110 c0",
                  busy, an, seg);
      end
      tick();
      clr  = 1'b1;
      load = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_load: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_scan;
      int exp_an;
      clr = 1'b0;
      #1;
      clr = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         tick();
         exp_an = ~(1 << ((n / 4) % 4)) & 4'hF;
         checks++;
         if (an !== 4'(exp_an) || seg !== exp_seg(0, (n / 4) % 4)) begin
            errors++;
            $display("FAIL scan: edge %0d an=%b seg=%h expected an=%b",
                     n, an, seg, 4'(exp_an));
         end
      end
      shown = 0;
   endtask

   task automatic test_fixed;
      do_load("v1234", 1234, -1, 0);
      do_load("v8191", 8191, -1, 0);
      do_load("v7", 7, -1, 0);
      do_load("v0", 0, -1, 0);
   endtask

   task automatic test_random;
      int lim [4] = '{9, 99, 999, 8191};
      int v;
      for (int i = 0; i < 10; i++) begin
         v = int'($urandom_range(0, lim[$urandom_range(0, 3)]));
         do_load("random", v, -1, 0);
      end
   endtask

   task automatic test_back_to_back;
      do_load("b2b_first", 1234, 4, 500);
   endtask

   task automatic test_foul;
      int n;
      int p;
      foul = 1'b1;
      #1;
      checks++;
      if (seg !== 8'hBF) begin
         errors++;
         $display("FAIL foul_now: seg=%h expected bf", seg);
      end
      tick();
      number = 13'd4321;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL foul_load: busy=%b expected 1", busy);
      end
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         checks++;
         if (seg !== 8'hBF || pos_of(an) < 0) begin
            errors++;
            $display("FAIL foul_dash: an=%b seg=%h expected bf", an, seg);
         end
         n++;
         tick();
      end
      checks++;
      if (n != 14) begin
         errors++;
         $display("FAIL foul_busy: busy cycles %0d expected 14", n);
      end
      foul = 1'b0;
      #1;
      p = pos_of(an);
      checks++;
      if (p < 0 || seg !== exp_seg(4321, p)) begin
         errors++;
         $display("FAIL foul_release: an=%b seg=%h expected 4321 digit",
                  an, seg);
      end
      tick();
      shown = 4321;
      check_display("foul_after", 4321);
   endtask

   task automatic test_reset_mid;
      number = 13'd4321;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      repeat (5) tick();
      #2;
      clr = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || an !== 4'b1110 || seg !== 8'hC0) begin
         errors++;
         $display("FAIL clr_mid: busy=%b an=%b seg=%h expected 0 1110 c0",
                  busy, an, seg);
      end
      #1;
      clr = 1'b1;
      tick();
      shown = 0;
      check_display("clr_mid_after", 0);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL clr_mid_busy: busy=%b expected 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_fixed();
      test_back_to_back();
      test_foul();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
